// File: rtl/register_file.sv
// Architectural register file with rename tags for the Tomasulo core.
// Answers decoder operand queries combinationally; updates on issue, commit and flush.
module register_file #(
    parameter int unsigned ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic [4:0]               get_reg_id1,
    output logic [31:0]              rs1_val,
    output logic                     has_dep1,
    output logic [ROB_WIDTH_BIT-1:0] dep1,
    input  logic [4:0]               get_reg_id2,
    output logic [31:0]              rs2_val,
    output logic                     has_dep2,
    output logic [ROB_WIDTH_BIT-1:0] dep2,

    output logic [ROB_WIDTH_BIT-1:0] rob_query_id1,
    output logic [ROB_WIDTH_BIT-1:0] rob_query_id2,
    input  logic                     rob_query_ready1,
    input  logic                     rob_query_ready2,
    input  logic [31:0]              rob_query_value1,
    input  logic [31:0]              rob_query_value2,

    input  logic                     issue_valid,
    input  logic [4:0]               issue_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,

    input  logic                     commit_valid,
    input  logic [4:0]               commit_reg_id,
    input  logic [31:0]              commit_value,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,

    input  logic                     flush
);

    typedef struct packed {
        logic [31:0]              val;
        logic                     has_dep;
        logic [ROB_WIDTH_BIT-1:0] dep;
    } query_t;

    logic [31:0]              regs_q [32];
    logic [31:0]              regs_d [32];
    logic [ROB_WIDTH_BIT-1:0] tag_q  [32];
    logic [ROB_WIDTH_BIT-1:0] tag_d  [32];
    logic [31:0]              busy_q;
    logic [31:0]              busy_d;

    query_t q1, q2;

    // Priority: x0, idle register, same-cycle commit bypass, ROB forward, wait on tag.
    function automatic query_t resolve(input logic [4:0] id, input logic ready,
                                       input logic [31:0] rob_val);
        query_t q;
        q.val     = regs_q[id];
        q.has_dep = 1'b0;
        q.dep     = tag_q[id];
        if (id == 5'd0) begin
            q.val = '0;
            q.dep = '0;
        end else if (busy_q[id]) begin
            if (commit_valid && commit_rob_id == tag_q[id]) begin
                q.val = commit_value;
            end else if (ready) begin
                q.val = rob_val;
            end else begin
                q.has_dep = 1'b1;
            end
        end
        return q;
    endfunction

    always_comb begin
        q1 = resolve(get_reg_id1, rob_query_ready1, rob_query_value1);
        q2 = resolve(get_reg_id2, rob_query_ready2, rob_query_value2);
        rs1_val       = q1.val;
        has_dep1      = q1.has_dep;
        dep1          = q1.dep;
        rs2_val       = q2.val;
        has_dep2      = q2.has_dep;
        dep2          = q2.dep;
        rob_query_id1 = tag_q[get_reg_id1];
        rob_query_id2 = tag_q[get_reg_id2];
    end

    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy_in) begin
            if (commit_valid && commit_reg_id != 5'd0) begin
                regs_d[commit_reg_id] = commit_value;
                // A stale commit writes the value but keeps the newer rename live.
                if (tag_q[commit_reg_id] == commit_rob_id) begin
                    busy_d[commit_reg_id] = 1'b0;
                end
            end
            if (flush) begin
                busy_d = '0;
            end else if (issue_valid && issue_reg_id != 5'd0) begin
                busy_d[issue_reg_id] = 1'b1;
                tag_d[issue_reg_id]  = issue_rob_id;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
`define ROB_WIDTH_BIT 4

module tb_register_file;

    localparam int unsigned W = `ROB_WIDTH_BIT;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in;
    logic [4:0]    get_reg_id1, get_reg_id2;
    logic [31:0]   rs1_val, rs2_val;
    logic          has_dep1, has_dep2;
    logic [W-1:0]  dep1, dep2, rob_query_id1, rob_query_id2;
    logic          rob_query_ready1, rob_query_ready2;
    logic [31:0]   rob_query_value1, rob_query_value2;
    logic          issue_valid;
    logic [4:0]    issue_reg_id;
    logic [W-1:0]  issue_rob_id;
    logic          commit_valid;
    logic [4:0]    commit_reg_id;
    logic [31:0]   commit_value;
    logic [W-1:0]  commit_rob_id;
    logic          flush;

    int n_checks = 0;
    int n_fails  = 0;

    register_file #(.ROB_WIDTH_BIT(`ROB_WIDTH_BIT)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .get_reg_id1      (get_reg_id1),
        .rs1_val          (rs1_val),
        .has_dep1         (has_dep1),
        .dep1             (dep1),
        .get_reg_id2      (get_reg_id2),
        .rs2_val          (rs2_val),
        .has_dep2         (has_dep2),
        .dep2             (dep2),
        .rob_query_id1    (rob_query_id1),
        .rob_query_id2    (rob_query_id2),
        .rob_query_ready1 (rob_query_ready1),
        .rob_query_ready2 (rob_query_ready2),
        .rob_query_value1 (rob_query_value1),
        .rob_query_value2 (rob_query_value2),
        .issue_valid      (issue_valid),
        .issue_reg_id     (issue_reg_id),
        .issue_rob_id     (issue_rob_id),
        .commit_valid     (commit_valid),
        .commit_reg_id    (commit_reg_id),
        .commit_value     (commit_value),
        .commit_rob_id    (commit_rob_id),
        .flush            (flush)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [4:0] r, input logic [W-1:0] rob);
        issue_valid  = 1'b1;
        issue_reg_id = r;
        issue_rob_id = rob;
        tick();
        issue_valid  = 1'b0;
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        get_reg_id1 = '0; get_reg_id2 = '0;
        rob_query_ready1 = 1'b0; rob_query_ready2 = 1'b0;
        rob_query_value1 = '0; rob_query_value2 = '0;
        issue_valid = 1'b0; issue_reg_id = '0; issue_rob_id = '0;
        commit_valid = 1'b0; commit_reg_id = '0; commit_value = '0; commit_rob_id = '0;
        tick();
        tick();
        rst_in = 1'b0;

        get_reg_id1 = 5'd5; get_reg_id2 = 5'd0;
        #1;
        check("rst_x5_val", rs1_val, 32'h0);
        check("rst_x5_dep", {31'b0, has_dep1}, 32'h0);
        check("rst_x0_val", rs2_val, 32'h0);
        check("rst_x0_dep", {31'b0, has_dep2}, 32'h0);

        // Writes to x0 are dropped.
        commit_valid = 1'b1; commit_reg_id = 5'd0; commit_value = 32'hDEADBEEF; commit_rob_id = '0;
        tick();
        commit_valid = 1'b0;
        get_reg_id1 = 5'd0;
        #1;
        check("x0_after_commit", rs1_val, 32'h0);

        // Rename x3 -> ROB 2; same-cycle query still sees the old mapping.
        get_reg_id1 = 5'd3;
        issue_valid = 1'b1; issue_reg_id = 5'd3; issue_rob_id = 4'd2;
        #1;
        check("issue_same_cycle_dep", {31'b0, has_dep1}, 32'h0);
        tick();
        issue_valid = 1'b0;
        #1;
        check("x3_has_dep", {31'b0, has_dep1}, 32'h1);
        check("x3_dep", {28'b0, dep1}, 32'd2);
        check("x3_rob_query_id", {28'b0, rob_query_id1}, 32'd2);
        rob_query_ready1 = 1'b1; rob_query_value1 = 32'h55;
        #1;
        check("x3_rob_fwd_val", rs1_val, 32'h55);
        check("x3_rob_fwd_dep", {31'b0, has_dep1}, 32'h0);
        rob_query_ready1 = 1'b0; rob_query_value1 = '0;

        // Commit bypass in the same cycle, then architectural state afterwards.
        commit_valid = 1'b1; commit_reg_id = 5'd3; commit_value = 32'h1234; commit_rob_id = 4'd2;
        #1;
        check("x3_bypass_val", rs1_val, 32'h1234);
        check("x3_bypass_dep", {31'b0, has_dep1}, 32'h0);
        tick();
        commit_valid = 1'b0;
        #1;
        check("x3_committed_val", rs1_val, 32'h1234);
        check("x3_committed_dep", {31'b0, has_dep1}, 32'h0);

        // Stale commit: older tag writes value, newer rename stays live.
        issue(5'd4, 4'd1);
        issue(5'd4, 4'd3);
        commit_valid = 1'b1; commit_reg_id = 5'd4; commit_value = 32'hAA; commit_rob_id = 4'd1;
        tick();
        commit_valid = 1'b0;
        get_reg_id1 = 5'd4;
        #1;
        check("x4_stale_val", rs1_val, 32'hAA);
        check("x4_stale_dep", {31'b0, has_dep1}, 32'h1);
        check("x4_stale_tag", {28'b0, dep1}, 32'd3);

        // Issue and commit to x7 in one cycle: issue wins busy/tag.
        issue_valid = 1'b1; issue_reg_id = 5'd7; issue_rob_id = 4'd5;
        commit_valid = 1'b1; commit_reg_id = 5'd7; commit_value = 32'h77; commit_rob_id = 4'd4;
        tick();
        issue_valid = 1'b0; commit_valid = 1'b0;
        get_reg_id2 = 5'd7;
        #1;
        check("x7_val", rs2_val, 32'h77);
        check("x7_dep", {31'b0, has_dep2}, 32'h1);
        check("x7_tag", {28'b0, dep2}, 32'd5);
        check("x7_rob_query_id", {28'b0, rob_query_id2}, 32'd5);

        // Flush with a concurrent issue and commit.
        issue(5'd1, 4'd0);
        issue(5'd2, 4'd1);
        flush = 1'b1;
        issue_valid = 1'b1; issue_reg_id = 5'd9; issue_rob_id = 4'd2;
        commit_valid = 1'b1; commit_reg_id = 5'd5; commit_value = 32'h55AA; commit_rob_id = 4'd9;
        tick();
        flush = 1'b0; issue_valid = 1'b0; commit_valid = 1'b0;
        get_reg_id1 = 5'd1; get_reg_id2 = 5'd2;
        #1;
        check("flush_x1_dep", {31'b0, has_dep1}, 32'h0);
        check("flush_x2_dep", {31'b0, has_dep2}, 32'h0);
        get_reg_id1 = 5'd9; get_reg_id2 = 5'd4;
        #1;
        check("flush_x9_dep", {31'b0, has_dep1}, 32'h0);
        check("flush_x9_tag", {28'b0, dep1}, 32'd0);
        check("flush_x4_dep", {31'b0, has_dep2}, 32'h0);
        get_reg_id1 = 5'd7; get_reg_id2 = 5'd5;
        #1;
        check("flush_x7_dep", {31'b0, has_dep1}, 32'h0);
        check("flush_commit_val", rs2_val, 32'h55AA);

        // rdy_in low holds state.
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_reg_id = 5'd6; issue_rob_id = 4'd7;
        commit_valid = 1'b1; commit_reg_id = 5'd6; commit_value = 32'h66; commit_rob_id = 4'd0;
        tick();
        rdy_in = 1'b1; issue_valid = 1'b0; commit_valid = 1'b0;
        get_reg_id1 = 5'd6;
        #1;
        check("stall_x6_dep", {31'b0, has_dep1}, 32'h0);
        check("stall_x6_val", rs1_val, 32'h0);
        check("stall_x6_tag", {28'b0, dep1}, 32'd0);

        // Reset overrides a concurrent issue and clears state.
        rst_in = 1'b1;
        issue_valid = 1'b1; issue_reg_id = 5'd8; issue_rob_id = 4'd4;
        tick();
        rst_in = 1'b0; issue_valid = 1'b0;
        get_reg_id1 = 5'd8; get_reg_id2 = 5'd3;
        #1;
        check("rst_x8_dep", {31'b0, has_dep1}, 32'h0);
        check("rst_x8_tag", {28'b0, dep1}, 32'd0);
        check("rst_x3_val", rs2_val, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
